pc_sequencer: RTL and testbench

- Multicycle control FSM for the RV32I core.
- Sequences the program-counter register through fetch, execute, memory and writeback.
- Shares the single memory port between instruction fetch and load/store.
- Drives the PC's inc/load/ALU-select/disable controls so the PC advances exactly once per retired instruction.

---
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multicycle control FSM for the RV32I core: sequences fetch/exec/mem/writeback over one shared
// memory port and steers the PC so it advances exactly once per retired instruction.
module pc_sequencer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        mem_busy,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        branch_taken,
   input  logic        writes_rd,
   input  logic        halt,
   output logic [31:0] instr,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_sel,
   output logic        pc_inc,
   output logic        pc_load,
   output logic        pc_alu,
   output logic        pc_disable,
   output logic        rf_we,
   output logic        fault
);

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      StFetchReq,
      StFetchWait,
      StExec,
      StMemReq,
      StMemWait,
      StWb,
      StHalt,
      StFault
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] instr_q, instr_d;
   logic        load_q, store_q, jal_q, jalr_q, br_q, wrd_q;
   logic        load_d, store_d, jal_d, jalr_d, br_d, wrd_d;

   logic mem_read_d, mem_write_d, mem_sel_d, pc_inc_d, pc_load_d, pc_alu_d;
   logic pc_disable_d, rf_we_d, fault_d, wb_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      load_d  = load_q;
      store_d = store_q;
      jal_d   = jal_q;
      jalr_d  = jalr_q;
      br_d    = br_q;
      wrd_d   = wrd_q;
      unique case (state_q)
         StFetchReq: begin
            if (!mem_busy) begin
               state_d = StFetchWait;
               cnt_d   = 8'd0;
            end
         end
         StFetchWait: begin
            // ack has priority over an expiring counter
            if (mem_ack) begin
               instr_d = mem_rdata;
               state_d = StExec;
            end else if (cnt_q == TimeoutCnt) begin
               state_d = StFault;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StExec: begin
            load_d  = is_load;
            // a load+store decode is treated as a load, so the store flag is dropped
            store_d = is_store & ~is_load;
            jal_d   = is_jal;
            jalr_d  = is_jalr;
            br_d    = branch_taken;
            wrd_d   = writes_rd;
            if (halt) begin
               state_d = StHalt;
            end else if (is_load || is_store) begin
               state_d = StMemReq;
            end else begin
               state_d = StWb;
            end
         end
         StMemReq: begin
            if (!mem_busy) begin
               state_d = StMemWait;
               cnt_d   = 8'd0;
            end
         end
         StMemWait: begin
            if (mem_ack) begin
               state_d = StWb;
            end else if (cnt_q == TimeoutCnt) begin
               state_d = StFault;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StWb:    state_d = StFetchReq;
         StHalt:  state_d = StHalt;
         StFault: state_d = StFault;
         default: state_d = StFetchReq;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies match a Moore decode.
   always_comb begin
      wb_d         = (state_d == StWb);
      mem_read_d   = (state_d == StFetchReq) | ((state_d == StMemReq) & load_d);
      mem_write_d  = (state_d == StMemReq) & store_d & ~load_d;
      mem_sel_d    = (state_d == StMemReq) | (state_d == StMemWait);
      pc_disable_d = ~wb_d;
      pc_load_d    = wb_d & jalr_d;
      pc_alu_d     = wb_d & ~jalr_d & (jal_d | br_d);
      pc_inc_d     = wb_d & ~jalr_d & ~jal_d & ~br_d;
      rf_we_d      = wb_d & wrd_d & ~store_d;
      fault_d      = (state_d == StFault);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= StFetchReq;
         cnt_q      <= 8'd0;
         instr_q    <= 32'd0;
         load_q     <= 1'b0;
         store_q    <= 1'b0;
         jal_q      <= 1'b0;
         jalr_q     <= 1'b0;
         br_q       <= 1'b0;
         wrd_q      <= 1'b0;
         mem_read   <= 1'b1;
         mem_write  <= 1'b0;
         mem_sel    <= 1'b0;
         pc_inc     <= 1'b0;
         pc_load    <= 1'b0;
         pc_alu     <= 1'b0;
         pc_disable <= 1'b1;
         rf_we      <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         instr_q    <= instr_d;
         load_q     <= load_d;
         store_q    <= store_d;
         jal_q      <= jal_d;
         jalr_q     <= jalr_d;
         br_q       <= br_d;
         wrd_q      <= wrd_d;
         mem_read   <= mem_read_d;
         mem_write  <= mem_write_d;
         mem_sel    <= mem_sel_d;
         pc_inc     <= pc_inc_d;
         pc_load    <= pc_load_d;
         pc_alu     <= pc_alu_d;
         pc_disable <= pc_disable_d;
         rf_we      <= rf_we_d;
         fault      <= fault_d;
      end
   end

   assign instr = instr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with TIMEOUT = 4; output bundle order is
// {mem_read, mem_write, mem_sel, pc_inc, pc_load, pc_alu, pc_disable, rf_we, fault}.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        mem_busy = 1'b0, mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        is_load = 1'b0, is_store = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
   logic        branch_taken = 1'b0, writes_rd = 1'b0, halt = 1'b0;
   logic [31:0] instr;
   logic        mem_read, mem_write, mem_sel, pc_inc, pc_load, pc_alu, pc_disable, rf_we, fault;
   logic [8:0]  outs;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [8:0] OutFetchReq  = 9'b100000100;
   localparam logic [8:0] OutIdle      = 9'b000000100;  // FETCH_WAIT, EXEC, HALT
   localparam logic [8:0] OutMemLoad   = 9'b101000100;
   localparam logic [8:0] OutMemStore  = 9'b011000100;
   localparam logic [8:0] OutMemWait   = 9'b001000100;
   localparam logic [8:0] OutWbIncWe   = 9'b000100010;
   localparam logic [8:0] OutWbInc     = 9'b000100000;
   localparam logic [8:0] OutWbAluWe   = 9'b000001010;
   localparam logic [8:0] OutWbAlu     = 9'b000001000;
   localparam logic [8:0] OutWbLoadWe  = 9'b000010010;
   localparam logic [8:0] OutFault     = 9'b000000101;

   pc_sequencer #(.TIMEOUT(4)) dut (
      .clk(clk), .clr(clr), .mem_busy(mem_busy), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .is_load(is_load), .is_store(is_store), .is_jal(is_jal), .is_jalr(is_jalr),
      .branch_taken(branch_taken), .writes_rd(writes_rd), .halt(halt), .instr(instr),
      .mem_read(mem_read), .mem_write(mem_write), .mem_sel(mem_sel), .pc_inc(pc_inc),
      .pc_load(pc_load), .pc_alu(pc_alu), .pc_disable(pc_disable), .rf_we(rf_we), .fault(fault)
   );

   assign outs = {mem_read, mem_write, mem_sel, pc_inc, pc_load, pc_alu, pc_disable, rf_we, fault};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_flags();
      is_load = 0; is_store = 0; is_jal = 0; is_jalr = 0;
      branch_taken = 0; writes_rd = 0; halt = 0;
   endtask

   // From FETCH_REQ: one FETCH_WAIT cycle with ack, ending in EXEC.
   task automatic do_fetch(input logic [31:0] word);
      mem_busy = 0;
      tick();
      check("fetch_wait", 32'(outs), 32'(OutIdle));
      mem_ack = 1; mem_rdata = word;
      tick();
      mem_ack = 0;
      check("instr", instr, word);
      check("exec", 32'(outs), 32'(OutIdle));
   endtask

   initial begin
      tick(); tick();
      check("reset_outs", 32'(outs), 32'(OutFetchReq));
      check("reset_instr", instr, 32'd0);
      clr = 0;

      // ALU op: fetch (c2), exec (c3), WB (c4), next fetch (c5)
      do_fetch(32'h00500093);
      writes_rd = 1;
      tick();
      check("alu_wb", 32'(outs), 32'(OutWbIncWe));
      clear_flags();
      tick();
      check("alu_next_fetch", 32'(outs), 32'(OutFetchReq));

      // Load: busy for 3 MEM_REQ cycles, ack on 2nd MEM_WAIT cycle
      do_fetch(32'h00002083);
      is_load = 1; writes_rd = 1; mem_busy = 1;
      tick();
      for (int i = 0; i < 4; i++) begin
         mem_busy = (i < 3);
         check($sformatf("load_memreq%0d", i), 32'(outs), 32'(OutMemLoad));
         tick();
      end
      mem_busy = 0;
      check("load_memwait1", 32'(outs), 32'(OutMemWait));
      tick();
      check("load_memwait2", 32'(outs), 32'(OutMemWait));
      mem_ack = 1;
      tick();
      mem_ack = 0;
      check("load_wb", 32'(outs), 32'(OutWbIncWe));
      clear_flags();
      tick();
      check("load_next_fetch", 32'(outs), 32'(OutFetchReq));

      // Store: write request, no rf write
      do_fetch(32'h00112023);
      is_store = 1; writes_rd = 1;
      tick();
      check("store_memreq", 32'(outs), 32'(OutMemStore));
      tick();
      check("store_memwait", 32'(outs), 32'(OutMemWait));
      mem_ack = 1;
      tick();
      mem_ack = 0;
      check("store_wb", 32'(outs), 32'(OutWbInc));
      clear_flags();
      tick();

      // Load+store together behaves as a load
      do_fetch(32'h0000a003);
      is_load = 1; is_store = 1; writes_rd = 1;
      tick();
      check("ldst_memreq", 32'(outs), 32'(OutMemLoad));
      tick(); mem_ack = 1; tick(); mem_ack = 0;
      check("ldst_wb", 32'(outs), 32'(OutWbIncWe));
      clear_flags();
      tick();

      // JAL -> pc_alu
      do_fetch(32'h008000ef);
      is_jal = 1; writes_rd = 1;
      tick();
      check("jal_wb", 32'(outs), 32'(OutWbAluWe));
      clear_flags();
      tick();

      // JALR with branch_taken -> pc_load only
      do_fetch(32'h000080e7);
      is_jalr = 1; branch_taken = 1; writes_rd = 1;
      tick();
      check("jalr_wb", 32'(outs), 32'(OutWbLoadWe));
      clear_flags();
      tick();

      // Taken branch -> pc_alu, no rf write
      do_fetch(32'h00208463);
      branch_taken = 1;
      tick();
      check("branch_wb", 32'(outs), 32'(OutWbAlu));
      clear_flags();
      tick();

      // Ack on the 5th FETCH_WAIT cycle wins over the timeout
      mem_busy = 0;
      tick();
      for (int c = 1; c <= 4; c++) begin
         check($sformatf("late_wait%0d", c), 32'(outs), 32'(OutIdle));
         tick();
      end
      mem_ack = 1; mem_rdata = 32'hcafe0013;
      tick();
      mem_ack = 0;
      check("late_exec_instr", instr, 32'hcafe0013);
      check("late_exec_nofault", 32'(outs), 32'(OutIdle));
      tick();
      check("late_wb", 32'(outs), 32'(OutWbInc));
      tick();

      // Halt beats a concurrent load decode; held for 20 cycles
      do_fetch(32'h00100073);
      halt = 1; is_load = 1;
      tick();
      clear_flags();
      for (int i = 0; i < 20; i++) begin
         check($sformatf("halt%0d", i), 32'(outs), 32'(OutIdle));
         mem_ack = (i == 5);
         tick();
      end
      mem_ack = 0;
      clr = 1; tick(); clr = 0;
      check("halt_clr", 32'(outs), 32'(OutFetchReq));

      // No ack: fault after 5 FETCH_WAIT cycles, sticky
      tick();
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("to_wait%0d", c), 32'(outs), 32'(OutIdle));
         tick();
      end
      check("fault", 32'(outs), 32'(OutFault));
      mem_ack = 1;
      tick(); tick();
      mem_ack = 0;
      check("fault_sticky", 32'(outs), 32'(OutFault));
      clr = 1; tick(); clr = 0;
      check("fault_clr", 32'(outs), 32'(OutFetchReq));

      // clr during MEM_WAIT
      do_fetch(32'h12345678);
      is_load = 1;
      tick(); tick();
      check("pre_clr_memwait", 32'(outs), 32'(OutMemWait));
      clr = 1; tick(); clr = 0;
      clear_flags();
      check("memwait_clr_outs", 32'(outs), 32'(OutFetchReq));
      check("memwait_clr_instr", instr, 32'd0);
      do_fetch(32'h00000013);
      tick();
      check("post_clr_wb", 32'(outs), 32'(OutWbInc));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
